// File: rtl/quad_generator_if.sv
// ============================================================================
// Module   : quad_generator_if
// Brief    : Command/status bundle for the quadrature encoder emulator.
//            The index signal exists only when QUAD_GEN_INDEX_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface quad_generator_if #(
    parameter int COUNT_BITS  = 32,
    parameter int PERIOD_BITS = 16
);
    logic                          enable;
    logic signed [COUNT_BITS-1:0]  target;
    logic        [PERIOD_BITS-1:0] min_period;
    logic                          load;
    logic signed [COUNT_BITS-1:0]  load_value;
    logic                          quadA;
    logic                          quadB;
    logic signed [COUNT_BITS-1:0]  position;
    logic                          busy;
`ifdef QUAD_GEN_INDEX_EN
    logic                          index;
`endif

    // Controller side: issues commands, observes the emulated encoder.
    modport master (
        output enable, target, min_period, load, load_value,
        input  quadA, quadB, position, busy
`ifdef QUAD_GEN_INDEX_EN
        , input index
`endif
    );

    // Generator side.
    modport slave (
        input  enable, target, min_period, load, load_value,
        output quadA, quadB, position, busy
`ifdef QUAD_GEN_INDEX_EN
        , output index
`endif
    );
endinterface

`default_nettype wire

// File: rtl/quad_generator.sv
// ============================================================================
// Module   : quad_generator
// Brief    : Quadrature encoder emulator. Steps A/B phases one edge at a time
//            to move a tracked signed position toward a commanded target,
//            with a programmable minimum gap between edges.
//            Optional macro QUAD_GEN_INDEX_EN adds a once-per-revolution
//            index output with INDEX_COUNTS counts per revolution.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_generator #(
    parameter int COUNT_BITS  = 32,
    parameter int PERIOD_BITS = 16
`ifdef QUAD_GEN_INDEX_EN
    , parameter int INDEX_COUNTS = 400
`endif
) (
    input  logic            clk,
    input  logic            reset,
    quad_generator_if.slave bus
);

    localparam logic signed [COUNT_BITS-1:0] c_one = COUNT_BITS'(1);

    logic signed [COUNT_BITS-1:0]  r_position;
    logic        [1:0]             r_phase;
    logic                          r_quad_a;
    logic                          r_quad_b;
    logic        [PERIOD_BITS-1:0] r_wait;

    logic                          w_busy;
    logic                          w_forward;
    logic                          w_step;
    logic        [1:0]             w_phase_next;
    logic        [PERIOD_BITS-1:0] w_reload;

    // Step decision: direction from a plain signed compare, gated by the edge gap.
    always_comb begin
        w_busy       = (r_position != bus.target);
        w_forward    = (bus.target > r_position);
        w_step       = bus.enable && !bus.load && (r_wait == '0) && w_busy;
        w_phase_next = w_forward ? (r_phase + 2'd1) : (r_phase - 2'd1);
        // A min_period of zero behaves like one: an edge every clock.
        w_reload     = (bus.min_period == '0) ? '0 : (bus.min_period - 1'b1);
    end

    // Position, phase and A/B registers; load presets position without an edge.
    // Phase 0..3 maps to (A,B) = 00,10,11,01 so A = phase[1]^phase[0], B = phase[1].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_position <= '0;
            r_phase    <= 2'd0;
            r_quad_a   <= 1'b0;
            r_quad_b   <= 1'b0;
        end else if (bus.load) begin
            r_position <= bus.load_value;
        end else if (w_step) begin
            r_position <= w_forward ? (r_position + c_one) : (r_position - c_one);
            r_phase    <= w_phase_next;
            r_quad_a   <= w_phase_next[1] ^ w_phase_next[0];
            r_quad_b   <= w_phase_next[1];
        end
    end

    // Edge-gap counter: reloaded on each step, otherwise drains every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_step) begin
            r_wait <= w_reload;
        end else if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
        end
    end

`ifdef QUAD_GEN_INDEX_EN
    localparam int REV_BITS = (INDEX_COUNTS > 1) ? $clog2(INDEX_COUNTS) : 1;
    localparam logic [REV_BITS-1:0] c_rev_last = REV_BITS'(INDEX_COUNTS - 1);

    logic [REV_BITS-1:0] r_rev;
    logic [REV_BITS-1:0] w_rev_next;
    logic [1:0]          w_phase_after;
    logic                r_index;

    // Revolution counter follows steps in both directions and wraps; load zeroes it.
    always_comb begin
        w_rev_next    = r_rev;
        w_phase_after = r_phase;
        if (bus.load) begin
            w_rev_next = '0;
        end else if (w_step) begin
            w_phase_after = w_phase_next;
            if (w_forward) begin
                w_rev_next = (r_rev == c_rev_last) ? '0 : (r_rev + 1'b1);
            end else begin
                w_rev_next = (r_rev == '0) ? c_rev_last : (r_rev - 1'b1);
            end
        end
    end

    // Index is high while at revolution count 0 with phase 00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rev   <= '0;
            r_index <= 1'b1;
        end else begin
            r_rev   <= w_rev_next;
            r_index <= (w_rev_next == '0) && (w_phase_after == 2'd0);
        end
    end

    assign bus.index = r_index;
`endif

    assign bus.quadA    = r_quad_a;
    assign bus.quadB    = r_quad_b;
    assign bus.position = r_position;
    assign bus.busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_quad_generator.sv
// ============================================================================
// Module   : tb_quad_generator
// Brief    : Directed self-checking bench for quad_generator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_quad_generator;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    quad_generator_if #(.COUNT_BITS(32), .PERIOD_BITS(16)) qif ();

    quad_generator #(
        .COUNT_BITS(32),
        .PERIOD_BITS(16)
`ifdef QUAD_GEN_INDEX_EN
        , .INDEX_COUNTS(4)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (qif)
    );

    int errors = 0;
    int checks = 0;

    logic [1:0]         exp_ph;
    logic signed [31:0] exp_pos;

    function automatic logic [1:0] enc(input logic [1:0] ph);
        case (ph)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] dec_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        qif.enable     = 1'b0;
        qif.target     = '0;
        qif.min_period = '0;
        qif.load       = 1'b0;
        qif.load_value = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({qif.quadA, qif.quadB} !== 2'b00) begin errors++; $display("FAIL reset_ab got=%b want=00", {qif.quadA, qif.quadB}); end
        checks++; if (qif.position !== 32'sd0) begin errors++; $display("FAIL reset_pos got=%0d want=0", qif.position); end
        checks++; if (qif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", qif.busy); end
`ifdef QUAD_GEN_INDEX_EN
        checks++; if (qif.index !== 1'b1) begin errors++; $display("FAIL reset_index got=%b want=1", qif.index); end
`endif
        reset   = 1'b0;
        exp_ph  = 2'd0;
        exp_pos = 0;
    endtask

    task automatic test_forward();
        logic [1:0] prev_ab;
        logic [1:0] cur;
        int n    = 0;
        int last = 0;
        int dec  = 0;
        int exp_t;
        qif.target     = 32'sd8;
        qif.min_period = 16'd4;
        qif.enable     = 1'b1;
        prev_ab = {qif.quadA, qif.quadB};
        for (int t = 1; t <= 40; t++) begin
            tick();
            cur = {qif.quadA, qif.quadB};
            if (cur !== prev_ab) begin
                n++;
                exp_ph = exp_ph + 2'd1;
                exp_t  = (n == 1) ? 1 : last + 4;
                checks++; if (cur !== enc(exp_ph)) begin errors++; $display("FAIL fwd_ab edge=%0d got=%b want=%b", n, cur, enc(exp_ph)); end
                checks++; if (t != exp_t) begin errors++; $display("FAIL fwd_spacing edge=%0d got_t=%0d want_t=%0d", n, t, exp_t); end
                checks++; if ($countones(cur ^ prev_ab) != 1) begin errors++; $display("FAIL fwd_onebit got=%b prev=%b", cur, prev_ab); end
                case (2'(dec_idx(cur) - dec_idx(prev_ab)))
                    2'd1:    dec++;
                    2'd3:    dec--;
                    default: ;
                endcase
                last    = t;
                prev_ab = cur;
            end
        end
        exp_pos = 8;
        checks++; if (n != 8) begin errors++; $display("FAIL fwd_edges got=%0d want=8", n); end
        checks++; if (qif.position !== exp_pos) begin errors++; $display("FAIL fwd_pos got=%0d want=8", qif.position); end
        checks++; if (qif.busy !== 1'b0) begin errors++; $display("FAIL fwd_busy got=%b want=0", qif.busy); end
        checks++; if (dec != 8) begin errors++; $display("FAIL fwd_decoder got=%0d want=8", dec); end
    endtask

    task automatic test_reverse();
        logic [1:0] prev_ab;
        logic [1:0] cur;
        qif.target     = -32'sd3;
        qif.min_period = 16'd1;
        prev_ab = {qif.quadA, qif.quadB};
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_ph  = exp_ph - 2'd1;
            exp_pos = exp_pos - 1;
            cur = {qif.quadA, qif.quadB};
            checks++; if (cur !== enc(exp_ph)) begin errors++; $display("FAIL rev_ab step=%0d got=%b want=%b", i, cur, enc(exp_ph)); end
            checks++; if (qif.position !== exp_pos) begin errors++; $display("FAIL rev_pos step=%0d got=%0d want=%0d", i, qif.position, exp_pos); end
            checks++; if ($countones(cur ^ prev_ab) != 1) begin errors++; $display("FAIL rev_onebit got=%b prev=%b", cur, prev_ab); end
            prev_ab = cur;
        end
        checks++; if (qif.busy !== 1'b0) begin errors++; $display("FAIL rev_busy got=%b want=0", qif.busy); end
        tick();
        checks++; if ({qif.quadA, qif.quadB} !== enc(exp_ph) || qif.position !== -32'sd3) begin
            errors++; $display("FAIL rev_hold got_ab=%b got_pos=%0d want_ab=%b want_pos=-3", {qif.quadA, qif.quadB}, qif.position, enc(exp_ph));
        end
    endtask

    task automatic test_enable_gap();
        qif.target     = 32'sd5;
        qif.min_period = 16'd3;
        tick();
        exp_pos = exp_pos + 1;
        exp_ph  = exp_ph + 2'd1;
        checks++; if (qif.position !== exp_pos) begin errors++; $display("FAIL gap_first got=%0d want=%0d", qif.position, exp_pos); end
        tick();
        qif.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (qif.position !== exp_pos || {qif.quadA, qif.quadB} !== enc(exp_ph)) begin
                errors++; $display("FAIL gap_frozen cyc=%0d got_pos=%0d got_ab=%b want_pos=%0d want_ab=%b", i, qif.position, {qif.quadA, qif.quadB}, exp_pos, enc(exp_ph));
            end
        end
        qif.enable = 1'b1;
        tick();
        exp_pos = exp_pos + 1;
        exp_ph  = exp_ph + 2'd1;
        checks++; if (qif.position !== exp_pos) begin errors++; $display("FAIL gap_resume got=%0d want=%0d", qif.position, exp_pos); end
        for (int t = 0; t < 100 && qif.busy; t++) tick();
        checks++; if (qif.busy !== 1'b0) begin errors++; $display("FAIL gap_timeout busy=%b want=0", qif.busy); end
        exp_pos = 5;
        exp_ph  = exp_ph + 2'd2;
        checks++; if (qif.position !== exp_pos) begin errors++; $display("FAIL gap_final got=%0d want=5", qif.position); end
        checks++; if ({qif.quadA, qif.quadB} !== enc(exp_ph)) begin errors++; $display("FAIL gap_final_ab got=%b want=%b", {qif.quadA, qif.quadB}, enc(exp_ph)); end
        repeat (3) tick();
    endtask

    task automatic test_load_wrap();
        qif.min_period = 16'd1;
        qif.load       = 1'b1;
        qif.load_value = 32'sh7FFF_FFFF;
        qif.target     = 32'sh7FFF_FFFF;
        tick();
        exp_pos = 32'sh7FFF_FFFF;
        checks++; if (qif.position !== exp_pos) begin errors++; $display("FAIL load_pos got=%h want=%h", qif.position, exp_pos); end
        checks++; if ({qif.quadA, qif.quadB} !== enc(exp_ph)) begin errors++; $display("FAIL load_noedge got=%b want=%b", {qif.quadA, qif.quadB}, enc(exp_ph)); end
        checks++; if (qif.busy !== 1'b0) begin errors++; $display("FAIL load_busy got=%b want=0", qif.busy); end
        qif.load   = 1'b0;
        qif.target = 32'sh8000_0000;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_pos = exp_pos - 1;
            exp_ph  = exp_ph - 2'd1;
            checks++; if (qif.position !== exp_pos || {qif.quadA, qif.quadB} !== enc(exp_ph)) begin
                errors++; $display("FAIL longway step=%0d got_pos=%h got_ab=%b want_pos=%h want_ab=%b", i, qif.position, {qif.quadA, qif.quadB}, exp_pos, enc(exp_ph));
            end
        end
        qif.load       = 1'b1;
        qif.load_value = 32'sh8000_0000;
        qif.target     = 32'sh7FFF_FFFF;
        tick();
        checks++; if (qif.position !== 32'sh8000_0000 || {qif.quadA, qif.quadB} !== enc(exp_ph)) begin
            errors++; $display("FAIL load_min got_pos=%h got_ab=%b want_pos=80000000 want_ab=%b", qif.position, {qif.quadA, qif.quadB}, enc(exp_ph));
        end
        checks++; if (qif.busy !== 1'b1) begin errors++; $display("FAIL load_min_busy got=%b want=1", qif.busy); end
        qif.load = 1'b0;
        tick();
        exp_ph = exp_ph + 2'd1;
        checks++; if (qif.position !== 32'sh8000_0001) begin errors++; $display("FAIL min_fwd got=%h want=80000001", qif.position); end
        qif.load       = 1'b1;
        qif.load_value = 32'sh7FFF_FFFF;
        tick();
        qif.load = 1'b0;
        repeat (3) tick();
        checks++; if (qif.position !== 32'sh7FFF_FFFF) begin errors++; $display("FAIL max_hold got=%h want=7fffffff", qif.position); end
    endtask

    task automatic test_async_reset();
        qif.load       = 1'b1;
        qif.load_value = '0;
        qif.target     = '0;
        tick();
        qif.load       = 1'b0;
        qif.target     = 32'sd6;
        qif.min_period = 16'd2;
        repeat (3) tick();
        checks++; if (qif.position !== 32'sd2) begin errors++; $display("FAIL ar_pre got=%0d want=2", qif.position); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({qif.quadA, qif.quadB} !== 2'b00 || qif.position !== 32'sd0) begin
            errors++; $display("FAIL ar_clear got_ab=%b got_pos=%0d want_ab=00 want_pos=0", {qif.quadA, qif.quadB}, qif.position);
        end
        #2;
        reset = 1'b0;
        tick();
        checks++; if (qif.position !== 32'sd1 || {qif.quadA, qif.quadB} !== 2'b10) begin
            errors++; $display("FAIL ar_restart got_ab=%b got_pos=%0d want_ab=10 want_pos=1", {qif.quadA, qif.quadB}, qif.position);
        end
        for (int t = 0; t < 100 && qif.busy; t++) tick();
        checks++; if (qif.position !== 32'sd6 || {qif.quadA, qif.quadB} !== enc(2'd2)) begin
            errors++; $display("FAIL ar_final got_ab=%b got_pos=%0d want_ab=11 want_pos=6", {qif.quadA, qif.quadB}, qif.position);
        end
    endtask

`ifdef QUAD_GEN_INDEX_EN
    task automatic test_index();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (qif.index !== 1'b1) begin errors++; $display("FAIL idx_reset got=%b want=1", qif.index); end
        qif.target     = 32'sd9;
        qif.min_period = 16'd1;
        qif.enable     = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++; if (qif.index !== ((i % 4) == 0)) begin errors++; $display("FAIL idx_fwd pos=%0d got=%b want=%b", i, qif.index, ((i % 4) == 0)); end
        end
        qif.target = 32'sd0;
        for (int i = 8; i >= 0; i--) begin
            tick();
            checks++; if (qif.index !== ((i % 4) == 0)) begin errors++; $display("FAIL idx_rev pos=%0d got=%b want=%b", i, qif.index, ((i % 4) == 0)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_enable_gap();
        test_load_wrap();
        test_async_reset();
`ifdef QUAD_GEN_INDEX_EN
        test_index();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/quad_generator.md
# quad_generator

Quadrature encoder emulator: drives a pair of A/B phase outputs that step a tracked signed position toward a commanded target, with a programmable minimum interval between edges. It is the transmit-side counterpart of the quadrature counter. It feeds encoder inputs of downstream drives, and it is used in loopback to exercise the counter.

## Interface
- COUNT_BITS, 32, width of signed position/target
- PERIOD_BITS, 16, width of min_period
- INDEX_COUNTS, 400, counts per index revolution (used only with QUAD_GEN_INDEX_EN)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permit stepping; low freezes outputs
- target  in  COUNT_BITS  signed commanded position
- min_period  in  PERIOD_BITS  minimum clocks between successive edges; 0 treated as 1
- load  in  1  preset position to load_value, no edges emitted
- load_value  in  COUNT_BITS  signed preset value
- quadA, quadB  out  1 each  registered quadrature phases
- position  out  COUNT_BITS  signed count of edges emitted (registered)
- busy  out  1  combinational, position != target
- index  out  1  registered index (only with QUAD_GEN_INDEX_EN)

## Operation
- Reset: quadA=0, quadB=0, position=0, phase=0, wait counter=0, index=1 (rev counter 0).
- Phase sequence (A,B), forward: 00 -> 10 -> 11 -> 01 -> 00. Reverse walks backward. A forward step increments position and a reverse step decrements it, matching the counter's count-up sense.
- Step condition, evaluated each clock: enable=1, load=0, wait=0, position != target.
- Direction: forward if target > position (signed compare), else reverse.
- On a step: phase advances by one, A/B update, position changes by 1, and wait loads max(min_period,1)-1.
- When wait != 0 it decrements every clock, regardless of enable or busy.
- load has priority over stepping. position takes load_value, phase, A/B and wait are unchanged, and there is no edge. The index rev counter resets to 0.
- Only one phase bit toggles per step, ever.
- position wraps two's-complement. Target comparison is plain signed, so a target across the wrap is reached the long way.
- A target change mid-motion takes effect on the next step condition. A direction reversal obeys the same wait gap.
- enable low: no edges, position holds, and wait still counts down.

## Timing
- Latency: target sampled at edge k with wait=0 gives new A/B and position visible after edge k.
- Edge spacing is exactly max(min_period,1) clocks while busy. min_period=0 or 1 produces one edge per clock.
- min_period change applies at the next reload, not to a wait in progress.
- busy falls in the same cycle position reaches target.
- Asynchronous reset mid-motion immediately forces all reset values. Stepping resumes on the first clock edge after reset deasserts.

## Configuration
- QUAD_GEN_INDEX_EN defined: a rev counter 0..INDEX_COUNTS-1 tracks steps, incrementing forward and decrementing reverse, wrapping both ways. index is registered, high while rev counter = 0 and phase = 00, so it is high at reset.
- QUAD_GEN_INDEX_EN not defined: no rev counter, no index port. All other behaviour is identical.

## Test plan
- Reset, then target=8, min_period=4, enable=1 -> A/B walk 10,11,01,00,10,11,01,00; 8 edges spaced 4 clocks; position=8; busy low; decoder in loopback reads +8.
- At position 8, set target=-3, min_period=1 -> one edge per clock in the reverse sequence; position reaches -3 after 11 clocks; no two phases toggle together.
- Mid-motion: drop enable for 10 clocks, then raise it -> no edges while low; the first edge on re-enable is immediate if wait has expired; the final position is unchanged from the enable=1 case.
- load=1, load_value=0x7FFFFFFF, target=0x7FFFFFFF, then target=0x80000000 -> position steps down 2^32-1 edges (run a short prefix only); no edge on the load cycle. Separately, stepping forward from a preset of 0x7FFFFFFF with a forced target is not reachable; check that wrap only occurs via load.
- Assert reset asynchronously between clock edges mid-motion -> A/B/position zero before the next edge; stepping restarts toward target after deassert.
- With QUAD_GEN_INDEX_EN, INDEX_COUNTS=4, target=9 -> index high at positions 0, 4 and 8 only; reversing to 0 gives index high at 8, 4 and 0.
